// File: rtl/cache_types.sv
// Cache-side geometry constants and the line/burst adaptor state encoding.
package cache_types;

    localparam int unsigned S_OFFSET        = 5;
    localparam int unsigned LINE_WIDTH      = 8 * (2 ** S_OFFSET);
    localparam int unsigned BURST_WIDTH     = 64;
    localparam int unsigned BEATS_PER_LINE  = LINE_WIDTH / BURST_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

endpackage : cache_types

// File: rtl/rv32i_types.sv
// Shared RV32I bus word types.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

endpackage : rv32i_types

// File: rtl/cacheline_adaptor.sv
// Converts single-cycle cache line requests into 4-beat memory bursts and back,
// assembling read beats into line_o and serialising the latched write line onto burst_o.
module cacheline_adaptor
    import cache_types::*;
    import rv32i_types::*;
#(
    parameter int unsigned s_offset = S_OFFSET,
    parameter int unsigned s_burst  = BURST_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [8*(2**s_offset)-1:0]   line_i,
    output logic [8*(2**s_offset)-1:0]   line_o,
    input  rv32i_word                    address_i,
    input  logic                         read_i,
    input  logic                         write_i,
    output logic                         resp_o,

    input  logic [s_burst-1:0]           burst_i,
    output logic [s_burst-1:0]           burst_o,
    output rv32i_word                    address_o,
    output logic                         read_o,
    output logic                         write_o,
    input  logic                         resp_i
);

    localparam int unsigned LINE_W = 8 * (2 ** s_offset);
    localparam int unsigned BEATS  = LINE_W / s_burst;
    localparam int unsigned KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);
    localparam rv32i_word ADDR_MASK = ~((rv32i_word'(1) << s_offset) - rv32i_word'(1));

    adaptor_state_t       state;
    logic [KW-1:0]        k;
    logic [KW-1:0]        k_next;
    logic [LINE_W-1:0]    line_buf;

    assign k_next = k + KW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            line_buf  <= '0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_o <= 1'b0;
                    // Read has priority when both requests arrive together.
                    if (read_i) begin
                        address_o <= address_i & ADDR_MASK;
                        k         <= '0;
                        read_o    <= 1'b1;
                        state     <= READ;
                    end else if (write_i) begin
                        address_o <= address_i & ADDR_MASK;
                        k         <= '0;
                        line_buf  <= line_i;
                        burst_o   <= line_i[s_burst-1:0];
                        write_o   <= 1'b1;
                        state     <= WRITE;
                    end
                end

                READ: begin
                    if (resp_i) begin
                        line_o[k*s_burst +: s_burst] <= burst_i;
                        k <= k_next;
                        if (k == LAST_BEAT) begin
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end

                WRITE: begin
                    if (resp_i) begin
                        k <= k_next;
                        if (k == LAST_BEAT) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            burst_o <= line_buf[k_next*s_burst +: s_burst];
                        end
                    end
                end

                DONE: begin
                    resp_o <= 1'b0;
                    k      <= '0;
                    state  <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    resp_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: request table, directed burst
// corner cases and randomized bursts against a transaction-level model.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    cacheline_adaptor #(.s_offset(5), .s_burst(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    logic [255:0] model_line = '0;

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
        bit           exp_rd;
        bit           exp_wr;
        logic [31:0]  exp_addr;
        bit           chk_burst;
        logic [63:0]  exp_burst;
    } req_vec_t;

    req_vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_read_o"},    read_o,    '0);
        chk({tag, "_write_o"},   write_o,   '0);
        chk({tag, "_resp_o"},    resp_o,    '0);
        chk({tag, "_address_o"}, address_o, '0);
        chk({tag, "_burst_o"},   burst_o,   '0);
        chk({tag, "_line_o"},    line_o,    '0);
    endtask

    task automatic do_reset();
        rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        tick();
        tick();
        check_reset_state("reset");
        model_line = '0;
        rst = 1'b1;
    endtask

    // Four back-to-back beats; used to close out the request-table rows.
    task automatic finish_beats(input bit is_read);
        logic [255:0] data = rand_line();
        for (int b = 0; b < 4; b++) begin
            resp_i = 1'b1;
            burst_i = data[64*b +: 64];
            tick();
            if (b < 3) begin
                chk("tbl_read_o_busy",  read_o,  is_read);
                chk("tbl_write_o_busy", write_o, !is_read);
                chk("tbl_resp_o_busy",  resp_o,  '0);
            end
        end
        if (is_read) model_line = data;
        chk("tbl_resp_o_done", resp_o, 1'b1);
        chk("tbl_line_o_done", line_o, model_line);
        resp_i = 1'b0;
        tick();
        chk("tbl_resp_o_idle", resp_o, '0);
    endtask

    // mode 0: resp_i always 1; mode 1: random gaps; mode 2: fixed 1,0,0,1,1,0,1 pattern.
    task automatic run_burst(input bit wr, input logic [31:0] addr, input logic [255:0] wline,
                             input logic [255:0] rline, input int mode, input bit hold_req);
        bit          pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int          beats = 0;
        int          cyc = 0;
        bit          r;
        logic [31:0] exp_addr = {addr[31:5], 5'b0};

        read_i = !wr; write_i = wr; address_i = addr; line_i = wline; resp_i = 1'b0;
        tick();
        chk("acc_read_o",    read_o,    !wr);
        chk("acc_write_o",   write_o,   wr);
        chk("acc_address_o", address_o, exp_addr);

        while (beats < 4 && cyc < 200) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
                default: r = pat[cyc % 7];
            endcase
            if (wr) chk("wr_burst_o", burst_o, wline[64*beats +: 64]);
            resp_i  = r;
            burst_i = r ? rline[64*beats +: 64] : 64'($urandom);
            address_i = $urandom;
            line_i    = rand_line();
            if (!hold_req) begin
                read_i  = 1'($urandom_range(0, 1));
                write_i = 1'($urandom_range(0, 1));
            end
            tick();
            if (r) begin
                if (!wr) model_line[64*beats +: 64] = rline[64*beats +: 64];
                beats++;
            end
            cyc++;
            if (beats < 4) begin
                chk("busy_read_o",    read_o,    !wr);
                chk("busy_write_o",   write_o,   wr);
                chk("busy_resp_o",    resp_o,    '0);
                chk("busy_address_o", address_o, exp_addr);
                chk("busy_line_o",    line_o,    model_line);
            end
        end
        if (beats < 4) begin
            n_cmp++; n_bad++;
            $display("FAIL burst_bound: got %0d beats expected 4", beats);
        end

        chk("done_resp_o",  resp_o,  1'b1);
        chk("done_read_o",  read_o,  '0);
        chk("done_write_o", write_o, '0);
        chk("done_line_o",  line_o,  model_line);

        // A beat strobe during the completion cycle must not be taken.
        resp_i = 1'b1;
        burst_i = 64'($urandom);
        tick();
        chk("post_resp_o", resp_o, '0);
        chk("post_line_o", line_o, model_line);
        chk("post_read_o", read_o, '0);
        resp_i = 1'b0;
        if (!hold_req) begin
            read_i = 1'b0;
            write_i = 1'b0;
        end
    endtask

    initial begin
        logic [255:0] l1 = rand_line();
        logic [255:0] l2 = rand_line();
        logic [255:0] l3 = rand_line();
        logic [255:0] d;
        logic [255:0] r2;

        vecs[0] = '{0, 0, 32'hDEAD_BEEF, l1, 0, 0, 32'h0000_0000, 1, 64'h0};
        vecs[1] = '{1, 0, 32'h0000_1234, l1, 1, 0, 32'h0000_1220, 0, 64'h0};
        vecs[2] = '{0, 1, 32'hFFFF_FFFF, l1, 0, 1, 32'hFFFF_FFE0, 1, l1[63:0]};
        vecs[3] = '{1, 1, 32'h8000_003F, l2, 1, 0, 32'h8000_0020, 0, 64'h0};
        vecs[4] = '{0, 1, 32'h0000_0020, l3, 0, 1, 32'h0000_0020, 1, l3[63:0]};

        do_reset();

        foreach (vecs[i]) begin
            read_i = vecs[i].rd; write_i = vecs[i].wr;
            address_i = vecs[i].addr; line_i = vecs[i].line;
            tick();
            read_i = 1'b0; write_i = 1'b0;
            chk("tbl_read_o",    read_o,    vecs[i].exp_rd);
            chk("tbl_write_o",   write_o,   vecs[i].exp_wr);
            chk("tbl_address_o", address_o, vecs[i].exp_addr);
            if (vecs[i].chk_burst) chk("tbl_burst_o", burst_o, vecs[i].exp_burst);
            if (vecs[i].rd || vecs[i].wr) finish_beats(vecs[i].rd);
            else chk("tbl_resp_o_idle", resp_o, '0);
        end

        // Aligned address and ordered assembly of four consecutive beats.
        d = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run_burst(1'b0, 32'h0000_1234, '0, d, 0, 1'b0);
        chk("read_line_const", line_o, d);

        // Write serialisation with resp_i held high.
        run_burst(1'b1, 32'h0000_4567, rand_line(), '0, 0, 1'b0);

        // Gapped beat strobes.
        run_burst(1'b0, 32'h1000_0040, '0, rand_line(), 2, 1'b0);

        // Request held across completion: a second read follows from IDLE.
        r2 = rand_line();
        run_burst(1'b0, 32'h2000_0000, '0, rand_line(), 0, 1'b1);
        run_burst(1'b0, 32'h2000_0100, '0, r2, 1, 1'b1);
        chk("hold_second_line", line_o, r2);
        read_i = 1'b0;
        tick();

        // Reset in the middle of a read burst.
        read_i = 1'b1; address_i = 32'h0000_0abc;
        tick();
        read_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            resp_i = 1'b1; burst_i = 64'($urandom) | 64'h1;
            tick();
        end
        rst = 1'b0; resp_i = 1'b0;
        tick();
        check_reset_state("midrst");
        rst = 1'b1;
        model_line = '0;

        // Immediate request after reset release, then random traffic.
        run_burst(1'b0, 32'h0000_0fe0, '0, rand_line(), 1, 1'b0);
        for (int n = 0; n < 30; n++) begin
            run_burst(1'($urandom_range(0, 1)), $urandom, rand_line(), rand_line(), 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cacheline_adaptor

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter s_offset, default 5, meaning log2 of bytes per cache line; line width is 8*2**s_offset = 256 bits.
REQ-002 Parameter s_burst, default 64, meaning width of one memory beat in bits; beats per line = 256/64 = 4.
REQ-003 Port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1, meaning synchronous active-low reset; asserted when 0.
REQ-005 Port line_i, input, 256, meaning write line from cache (pmem_wdata).
REQ-006 Port line_o, output, 256, meaning read line to cache (pmem_rdata).
REQ-007 Port address_i, input, 32, meaning line address from cache (pmem_address).
REQ-008 Port read_i, input, 1, meaning cache line-read request.
REQ-009 Port write_i, input, 1, meaning cache line-write request.
REQ-010 Port resp_o, output, 1, meaning one-cycle line-transfer-complete pulse to cache.
REQ-011 Port burst_i, input, 64, meaning read beat from memory.
REQ-012 Port burst_o, output, 64, meaning write beat to memory.
REQ-013 Port address_o, output, 32, meaning burst address to memory.
REQ-014 Port read_o, output, 1, meaning burst-read request to memory.
REQ-015 Port write_o, output, 1, meaning burst-write request to memory.
REQ-016 Port resp_i, input, 1, meaning memory beat strobe; one beat transfers on every rising edge with resp_i=1.

Function
REQ-017 The FSM has states IDLE, READ, WRITE and DONE, and all outputs are registered.
REQ-018 In IDLE, read_i=1 latches address_i with bits [4:0] forced to 0, clears the beat counter, and enters READ with read_o=1 on the next cycle.
REQ-019 In IDLE, write_i=1 (read_i=0) additionally latches line_i and enters WRITE with write_o=1 and burst_o=line_i[63:0] on the next cycle.
REQ-020 When read_i and write_i are both 1 in IDLE, read wins and write_i is ignored.
REQ-021 In READ, each edge with resp_i=1 stores burst_i into line_o[64k+63:64k], where k is the 2-bit beat counter, then increments k.
REQ-022 In WRITE, burst_o shows beat k of the latched line, and each edge with resp_i=1 advances k.
REQ-023 On the edge that transfers beat 3, read_o and write_o go to 0, the FSM enters DONE, and resp_o=1 for exactly that one cycle.
REQ-024 DONE returns to IDLE unconditionally, and requests are sampled again from the IDLE cycle onward.
REQ-025 The beat counter wraps from 3 to 0 only through DONE, and a single burst never takes more than 4 beats.
REQ-026 resp_i in IDLE or DONE is ignored, and read_i, write_i, address_i and line_i changes during READ or WRITE are ignored.
REQ-027 line_o holds its last assembled value until the next read burst writes it, and partial values are visible during a burst.
REQ-028 address_o holds the latched aligned address for the whole burst.
REQ-029 Gaps in resp_i (resp_i=0 between beats) stall the counter without losing data.
REQ-030 There is no internal timeout.

Reset
REQ-031 rst=0 at a rising edge forces IDLE, k=0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0 and line_o=0, including mid-burst.
REQ-032 The first request is accepted in the first IDLE cycle after rst returns to 1.

Structure
REQ-033 Constants (line width, beat width, beats per line) and the state enum live in the shared cache_types package.
REQ-034 Bus words use rv32i_word from rv32i_types.
REQ-035 The block is a single module with no sub-module, and the existing register module is not required.

Verification
REQ-036 Reset mid-READ after 2 beats -> next cycle read_o=0, resp_o=0, line_o=0, state IDLE.
REQ-037 Read address_i=0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles -> address_o=0x0000_1220, line_o={0x44..44,0x33..33,0x22..22,0x11..11}, resp_o high exactly 1 cycle after the 4th beat.
REQ-038 Write line_i={D3,D2,D1,D0} with resp_i held high -> burst_o=D0,D1,D2,D3 on successive beat edges, write_o drops with the 4th beat, and resp_o pulses once.
REQ-039 Read with resp_i pattern 1,0,0,1,1,0,1 -> 4 beats captured in order, and no extra beat is taken.
REQ-040 read_i=write_i=1 in IDLE -> read_o=1, write_o stays 0.
REQ-041 read_i held high across resp_o -> a second burst starts from IDLE, and beats from the first burst do not reappear.
